// File: rtl/fp_accum_seq_if.sv
// Handshake bundle between the accumulation sequencer, its operand source,
// result consumer and the external fp_arith add/sub datapath.
interface fp_accum_seq_if #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 8
);
    logic                  start;
    logic [CNT_WIDTH-1:0]  len;
    logic                  op_sel;
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_ready;
    logic                  arith_en;
    logic [DATA_WIDTH-1:0] arith_a;
    logic [DATA_WIDTH-1:0] arith_b;
    logic                  arith_op;
    logic [DATA_WIDTH-1:0] arith_res;
    logic                  res_valid;
    logic [DATA_WIDTH-1:0] res_data;
    logic                  res_ready;
    logic                  busy;

    modport master (
        output start, len, op_sel, in_valid, in_data, arith_res, res_ready,
        input  in_ready, arith_en, arith_a, arith_b, arith_op, res_valid, res_data, busy
    );

    modport slave (
        input  start, len, op_sel, in_valid, in_data, arith_res, res_ready,
        output in_ready, arith_en, arith_a, arith_b, arith_op, res_valid, res_data, busy
    );
endinterface

// File: rtl/fp_accum_seq.sv
// Folds a stream of LEN FP32 operands into an accumulator (acc +/- x) using an
// external combinational fp_arith, then hands the final value to a consumer.
module fp_accum_seq #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    CNT_WIDTH  = 8,
    parameter logic [DATA_WIDTH-1:0] ACCUM_INIT = '0
) (
    input logic           clk,
    input logic           rst,
    fp_accum_seq_if.slave bus
);
    typedef enum logic [2:0] {IDLE, FIRST, ACCEPT, EXEC, DONE} state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] acc;
    logic [DATA_WIDTH-1:0] opnd_q;
    logic [CNT_WIDTH-1:0]  cnt;
    logic [CNT_WIDTH-1:0]  len_q;
    logic [CNT_WIDTH-1:0]  cnt_next;
    logic                  op_q;
    logic                  in_ready;
    logic                  arith_en;
    logic                  res_valid;
    logic                  busy;

    // Registered outputs {in_ready, arith_en, res_valid, busy} for the state being entered.
    function automatic logic [3:0] state_outs(input state_t s);
        logic [3:0] o;
        case (s)
            FIRST, ACCEPT: o = 4'b1001;
            EXEC:          o = 4'b0101;
            DONE:          o = 4'b0011;
            default:       o = 4'b0000;
        endcase
        return o;
    endfunction

    // cnt stays below len_q while in EXEC, so the increment cannot wrap.
    assign cnt_next = cnt + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state                                  <= IDLE;
            acc                                    <= ACCUM_INIT;
            opnd_q                                 <= '0;
            cnt                                    <= '0;
            len_q                                  <= '0;
            op_q                                   <= 1'b0;
            {in_ready, arith_en, res_valid, busy}  <= state_outs(IDLE);
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (bus.len != '0) begin
                            len_q                                 <= bus.len;
                            op_q                                  <= bus.op_sel;
                            cnt                                   <= '0;
                            state                                 <= FIRST;
                            {in_ready, arith_en, res_valid, busy} <= state_outs(FIRST);
                        end else begin
                            acc                                   <= ACCUM_INIT;
                            state                                 <= DONE;
                            {in_ready, arith_en, res_valid, busy} <= state_outs(DONE);
                        end
                    end
                end
                // First operand is loaded verbatim: fp_arith forces the hidden bit and
                // cannot take a zero accumulator, and no negation is applied for subtract.
                FIRST: begin
                    if (bus.in_valid) begin
                        acc <= bus.in_data;
                        cnt <= CNT_WIDTH'(1);
                        if (len_q == CNT_WIDTH'(1)) begin
                            state                                 <= DONE;
                            {in_ready, arith_en, res_valid, busy} <= state_outs(DONE);
                        end else begin
                            state                                 <= ACCEPT;
                            {in_ready, arith_en, res_valid, busy} <= state_outs(ACCEPT);
                        end
                    end
                end
                ACCEPT: begin
                    if (bus.in_valid) begin
                        opnd_q                                <= bus.in_data;
                        state                                 <= EXEC;
                        {in_ready, arith_en, res_valid, busy} <= state_outs(EXEC);
                    end
                end
                EXEC: begin
                    acc <= bus.arith_res;
                    cnt <= cnt_next;
                    if (cnt_next == len_q) begin
                        state                                 <= DONE;
                        {in_ready, arith_en, res_valid, busy} <= state_outs(DONE);
                    end else begin
                        state                                 <= ACCEPT;
                        {in_ready, arith_en, res_valid, busy} <= state_outs(ACCEPT);
                    end
                end
                DONE: begin
                    if (bus.res_ready) begin
                        state                                 <= IDLE;
                        {in_ready, arith_en, res_valid, busy} <= state_outs(IDLE);
                    end
                end
                default: begin
                    state                                 <= IDLE;
                    {in_ready, arith_en, res_valid, busy} <= state_outs(IDLE);
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.arith_en  = arith_en;
    assign bus.arith_a   = acc;
    assign bus.arith_b   = opnd_q;
    assign bus.arith_op  = op_q;
    assign bus.res_valid = res_valid;
    assign bus.res_data  = acc;
    assign bus.busy      = busy;
endmodule
